// File: rtl/counter_bin_ctrl.sv
// Bin sequencer and ring-buffer controller for the counter SRAM (port A writes, port B reads).
// Define COUNTER_BIN_OVERWRITE_EN to overwrite the oldest word when full instead of dropping the bin.
module counter_bin_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned DEPTH      = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_trig_en,
    input  logic                  i_trig,
    input  logic                  i_event,
    input  logic [31:0]           i_bin_len,
    input  logic [31:0]           i_num_bins,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_we,
    output logic [DATA_WIDTH-1:0] o_sram_data,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic                  i_pop,
    output logic                  o_rd_valid,
    output logic [ADDR_WIDTH:0]   o_fill,
    output logic                  o_overflow,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StWaitTrig = 2'd1;
    localparam logic [1:0] StCount    = 2'd2;
    localparam logic [1:0] StDone     = 2'd3;

    localparam logic [DATA_WIDTH-1:0] AccMax = '1;
    localparam logic [ADDR_WIDTH+1:0] DepthW = (ADDR_WIDTH + 2)'(DEPTH);

    logic [1:0]            state_q, state_d;
    logic [31:0]           len_q, len_d, num_q, num_d, timer_q, timer_d, bins_q, bins_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, data_q, data_d, acc_sum;
    logic [ADDR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic                  we_q, we_d, ow_q, ow_d, ovf_q, ovf_d;
    logic                  valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic                  pop_fire, ow_commit, full;
    logic [ADDR_WIDTH+1:0] occ;
    logic [31:0]           start_len;

    always_comb begin
        pop_fire  = i_pop & valid_q;
        ow_commit = we_q & ow_q;
        // Occupancy counts the word in flight so back-to-back bins see a full buffer in time.
        occ       = {1'b0, fill_q} + (ADDR_WIDTH + 2)'(we_q) - (ADDR_WIDTH + 2)'(pop_fire);
        full      = (occ >= DepthW);
        acc_sum   = (acc_q == AccMax) ? acc_q : acc_q + DATA_WIDTH'(i_event);
        start_len = (i_bin_len == 32'd0) ? 32'd1 : i_bin_len;

        state_d = state_q;
        len_d   = len_q;
        num_d   = num_q;
        timer_d = timer_q;
        bins_d  = bins_q;
        acc_d   = acc_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        ow_d    = 1'b0;
        wr_d    = wr_q + ADDR_WIDTH'(we_q);
        rd_d    = rd_q + ADDR_WIDTH'(pop_fire) + ADDR_WIDTH'(ow_commit);
        fill_d  = fill_q + (ADDR_WIDTH + 1)'(we_q & ~ow_q) - (ADDR_WIDTH + 1)'(pop_fire);

        unique case (state_q)
            StWaitTrig: begin
                if (i_trig) begin
                    state_d = StCount;
                    timer_d = len_q - 32'd1;
                    acc_d   = '0;
                end
            end
            StCount: begin
                if (timer_q == 32'd0) begin
                    if (full) begin
                        ovf_d = 1'b1;
`ifdef COUNTER_BIN_OVERWRITE_EN
                        we_d   = 1'b1;
                        ow_d   = 1'b1;
                        data_d = acc_sum;
`endif
                    end else begin
                        we_d   = 1'b1;
                        data_d = acc_sum;
                    end
                    acc_d   = '0;
                    timer_d = len_q - 32'd1;
                    bins_d  = bins_q + 32'd1;
                    if (num_q != 32'd0 && bins_q + 32'd1 == num_q) begin
                        state_d = StDone;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                    acc_d   = acc_sum;
                end
            end
            default: ;
        endcase

        if (i_stop) begin
            state_d = StIdle;
            we_d    = 1'b0;
            ow_d    = 1'b0;
            data_d  = data_q;
            ovf_d   = ovf_q;
        end

        if (i_start && (state_q == StIdle || state_q == StDone)) begin
            state_d = i_trig_en ? StWaitTrig : StCount;
            len_d   = start_len;
            num_d   = i_num_bins;
            timer_d = start_len - 32'd1;
            bins_d  = '0;
            acc_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            fill_d  = '0;
            ovf_d   = 1'b0;
            we_d    = 1'b0;
            ow_d    = 1'b0;
        end

        // Port B data lags the address by one cycle, so hold valid off after any move.
        valid_d = (fill_d != '0) && (fill_q != '0) && (rd_d == rd_q);
        busy_d  = (state_d == StWaitTrig) || (state_d == StCount);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            len_q   <= 32'd1;
            num_q   <= '0;
            timer_q <= '0;
            bins_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            we_q    <= 1'b0;
            ow_q    <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            timer_q <= timer_d;
            bins_q  <= bins_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
            we_q    <= we_d;
            ow_q    <= ow_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_sram_addr = wr_q;
    assign o_sram_we   = we_q;
    assign o_sram_data = data_q;
    assign o_rd_addr   = rd_q;
    assign o_rd_valid  = valid_q;
    assign o_fill      = fill_q;
    assign o_overflow  = ovf_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: doc/counter_bin_ctrl.md
# counter_bin_ctrl

Sequencer and ring-buffer controller for the counter SRAM. Time is divided into contiguous bins. Events are accumulated per bin, and each finished bin's count is written through the SRAM write/counter port (port A) at an auto-incrementing, wrapping address. The block also maintains the read pointer and fill level for the host/system-bus side (port B), so software drains samples while counting continues.

## Interface
Parameters:
- ADDR_WIDTH, 12, SRAM address width
- DATA_WIDTH, 18, SRAM word width and per-bin count width
- DEPTH, 4096, SRAM words; must equal 2**ADDR_WIDTH

Ports:
- i_clk  in  1  single clock for all logic
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  pulse: clear pointers/flags, begin acquisition
- i_stop  in  1  pulse: abort acquisition, return to IDLE
- i_trig_en  in  1  sampled at i_start; 1 = wait for i_trig before counting
- i_trig  in  1  synchronous trigger pulse
- i_event  in  1  synchronous single-cycle count event
- i_bin_len  in  32  cycles per bin; 0 treated as 1
- i_num_bins  in  32  bins to acquire; 0 = continuous
- o_sram_addr  out  ADDR_WIDTH  port A address (write pointer)
- o_sram_we  out  1  port A write enable, one-cycle pulse per bin
- o_sram_data  out  DATA_WIDTH  port A write data (bin count)
- o_rd_addr  out  ADDR_WIDTH  port B address (read pointer); port B write enable is never driven by this block
- i_pop  in  1  host consumed word at o_rd_addr
- o_rd_valid  out  1  fill > 0 and port B data for o_rd_addr is valid
- o_fill  out  ADDR_WIDTH+1  words stored, 0..DEPTH
- o_overflow  out  1  sticky: a bin arrived while full
- o_busy  out  1  state is WAIT_TRIG or COUNT
- o_done  out  1  state is DONE

## Operation
- States: IDLE, WAIT_TRIG, COUNT, DONE.
- IDLE/DONE on i_start:
  - clear write/read pointers, fill, overflow, bin counter
  - latch i_bin_len, i_num_bins, i_trig_en
  - go to WAIT_TRIG if i_trig_en, else COUNT
- WAIT_TRIG on i_trig: go to COUNT.
- i_stop in any state goes to IDLE. The partial bin is discarded; stored data and pointers are kept.
- i_start has priority over i_stop in the same cycle.
- COUNT:
  - Bin timer loads latched bin_len-1 on entry and counts down.
  - The event accumulator adds i_event every cycle and saturates at 2**DATA_WIDTH-1.
  - On the cycle with timer==0, the count including that cycle's i_event is issued as a write. The accumulator and timer reload with no dead cycle, so bins are contiguous.
  - After the write of bin num_bins (num_bins≠0), go to DONE.
- Write pointer: increments modulo DEPTH after each accepted write.
- Read pointer: increments modulo DEPTH on i_pop when fill>0. i_pop with fill==0 is ignored.
- Fill: +1 per accepted write, −1 per effective pop. Simultaneous write and pop leaves fill unchanged.
- Full (fill==DEPTH) write behaviour depends on the configuration (see Configuration). o_overflow is set sticky in both cases and cleared only by i_start or reset.

## Timing
- Reset values:
  - state IDLE; all pointers and o_fill = 0
  - o_sram_we, o_sram_addr, o_sram_data = 0
  - o_rd_addr = 0; o_rd_valid, o_overflow, o_busy, o_done = 0
- All outputs are registered.
- o_sram_we/o_sram_data/o_sram_addr are asserted in the cycle after a bin's last cycle. The SRAM commits the word at the following edge.
- o_fill increments one cycle after o_sram_we, i.e. only once the word is committed. Pop decrements o_fill at the edge following i_pop.
- SRAM read latency is 1 cycle. o_rd_valid is deasserted for exactly one cycle after any o_rd_addr change or any 0→nonzero fill transition, then asserts if fill>0.
- i_pop is honoured only while o_rd_valid=1.
- Bin k occupies cycles [k·L, (k+1)·L) after COUNT entry, where L is the latched bin length.

## Configuration
- COUNTER_BIN_OVERWRITE_EN defined: when full, a new bin is written at the write pointer. The read pointer advances in the same edge (oldest word dropped), and fill stays DEPTH.
- Undefined: when full, the new bin is discarded. o_sram_we stays low and the pointers are unchanged.
- o_overflow sets in both cases.

## Test plan
- Basic binning: bin_len=4, num_bins=3, 2 events per bin → writes 2,2,2 at addresses 0,1,2; o_done=1; o_fill=3.
- Boundary and saturation: event on every cycle with bin_len=1 → each word =1. With DATA_WIDTH=4 and bin_len=20 under continuous events → word 15 (saturated).
- Wrap/full, both builds: DEPTH=8, no pops, 10 bins.
  - Without macro: fill=8, overflow=1, o_rd_addr=0, words are bins 0..7.
  - With macro: o_rd_addr=2, word 0 = bin 8.
- Simultaneous write and pop: fill=3, i_pop coincident with a commit → fill stays 3; o_rd_addr +1; o_rd_valid low exactly one cycle.
- Trigger/stop: i_trig_en=1, no trigger for 50 cycles → no writes. After i_trig, i_stop mid-bin → partial bin not written, state IDLE.
- Async reset mid-COUNT: assert i_rst → all outputs zero immediately without a clock edge; after release, the block stays IDLE until i_start.
